// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient loader.
// Holds the default tap geometry, the coefficient type and the loader state encoding.
// No logic; imported by fir_coeff_bank and fir_coeff_loader.
package fir_pkg;

  localparam int TAP_WIDTH_DEF = 32;
  localparam int TAP_COUNT_DEF = 102;

  typedef logic signed [TAP_WIDTH_DEF-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } loader_state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// Purpose: TAP_COUNT x TAP_WIDTH coefficient register bank, async zero reset.
// Latency: write port and parallel load both take effect on the next edge.
// Backpressure: none; always accepts. Parallel load has priority over the write port.
// Ports: clk/reset_n; we/addr/wdata single write port; load/load_flat full-bank
//        copy; q_flat exposes tap k at bits [k*TAP_WIDTH +: TAP_WIDTH].
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int TAP_WIDTH = TAP_WIDTH_DEF,
  parameter int TAP_COUNT = TAP_COUNT_DEF,
  parameter int IDX_WIDTH = $clog2(TAP_COUNT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           we,
  input  logic [IDX_WIDTH-1:0]           addr,
  input  logic [TAP_WIDTH-1:0]           wdata,
  input  logic                           load,
  input  logic [TAP_COUNT*TAP_WIDTH-1:0] load_flat,
  output logic [TAP_COUNT*TAP_WIDTH-1:0] q_flat
);

  logic [TAP_WIDTH-1:0] mem_q [TAP_COUNT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAP_COUNT; k++) mem_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < TAP_COUNT; k++) mem_q[k] <= load_flat[k*TAP_WIDTH +: TAP_WIDTH];
    end else if (we && (32'(addr) < TAP_COUNT)) begin
      mem_q[addr] <= wdata;
    end
  end

  for (genvar k = 0; k < TAP_COUNT; k++) begin : g_flat
    assign q_flat[k*TAP_WIDTH +: TAP_WIDTH] = mem_q[k];
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Purpose: runtime loader filling a shadow coefficient bank, committed atomically to the active bank.
// Latency: active bank updates one edge after the last word is accepted; coeff_update pulses the cycle after.
// Backpressure: cfg_ready is registered and high only while loading; words outside LOAD are ignored.
// Ports: clk, reset_n (async active-low); start pulse; cfg_valid/cfg_data/cfg_last/cfg_ready word
//        stream; taps_flat active bank; coeff_update, busy, load_err status.
// Optional: FIR_COEFF_READBACK_EN adds rd_addr/rd_data, a registered read of the active bank.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int TAP_WIDTH = TAP_WIDTH_DEF,
  parameter int TAP_COUNT = TAP_COUNT_DEF,
  parameter int IDX_WIDTH = $clog2(TAP_COUNT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           cfg_valid,
  input  logic signed [TAP_WIDTH-1:0]    cfg_data,
  input  logic                           cfg_last,
  output logic                           cfg_ready,
  output logic [TAP_COUNT*TAP_WIDTH-1:0] taps_flat,
  output logic                           coeff_update,
  output logic                           busy,
  output logic                           load_err
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [IDX_WIDTH-1:0]           rd_addr,
  output logic [TAP_WIDTH-1:0]           rd_data
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TAP_COUNT - 1);

  loader_state_t        state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 ready_q, busy_q, update_q;
  logic                 wr_en, commit;
  logic [TAP_COUNT*TAP_WIDTH-1:0] shadow_flat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ready_q  <= (state_d == LOAD);
      busy_q   <= (state_d != IDLE);
      update_q <= commit;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        // A restart wins over any word offered in the same cycle.
        if (start) begin
          idx_d = '0;
          err_d = 1'b0;
        end else if (cfg_valid && ready_q) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            if (cfg_last) begin
              state_d = COMMIT;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end else if (cfg_last) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fir_coeff_bank #(
    .TAP_WIDTH(TAP_WIDTH), .TAP_COUNT(TAP_COUNT), .IDX_WIDTH(IDX_WIDTH)
  ) u_shadow (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (wr_en),
    .addr     (idx_q),
    .wdata    (cfg_data),
    .load     (1'b0),
    .load_flat('0),
    .q_flat   (shadow_flat)
  );

  fir_coeff_bank #(
    .TAP_WIDTH(TAP_WIDTH), .TAP_COUNT(TAP_COUNT), .IDX_WIDTH(IDX_WIDTH)
  ) u_active (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (1'b0),
    .addr     ('0),
    .wdata    ('0),
    .load     (commit),
    .load_flat(shadow_flat),
    .q_flat   (taps_flat)
  );

  assign cfg_ready    = ready_q;
  assign busy         = busy_q;
  assign load_err     = err_q;
  assign coeff_update = update_q;

`ifdef FIR_COEFF_READBACK_EN
  logic [TAP_WIDTH-1:0] active_arr [TAP_COUNT];
  logic [TAP_WIDTH-1:0] rd_data_q;

  for (genvar k = 0; k < TAP_COUNT; k++) begin : g_rd
    assign active_arr[k] = taps_flat[k*TAP_WIDTH +: TAP_WIDTH];
  end

  // Reads the pre-commit bank during COMMIT, so the old value comes back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (32'(rd_addr) < TAP_COUNT) begin
      rd_data_q <= active_arr[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed frames checked against a frame-level model every cycle.
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int TW = TAP_WIDTH_DEF;
  localparam int TC = TAP_COUNT_DEF;
  localparam int IW = $clog2(TC);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [TW-1:0]     cfg_data = '0;
  logic              cfg_last = 1'b0;
  logic              cfg_ready;
  logic [TC*TW-1:0]  taps_flat;
  logic              coeff_update;
  logic              busy;
  logic              load_err;
`ifdef FIR_COEFF_READBACK_EN
  logic [IW-1:0]     rd_addr = '0;
  logic [TW-1:0]     rd_data;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  fir_coeff_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .cfg_ready   (cfg_ready),
    .taps_flat   (taps_flat),
    .coeff_update(coeff_update),
    .busy        (busy),
    .load_err    (load_err)
`ifdef FIR_COEFF_READBACK_EN
    ,
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- frame-level model ----------------
  logic [TW-1:0] m_active [TC];
  logic [TW-1:0] m_frame [$];
  bit            m_loading, m_commit, m_err, m_upd;
  logic [TW-1:0] m_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TC; k++) m_active[k] = '0;
      m_frame.delete();
      m_loading = 0; m_commit = 0; m_err = 0; m_upd = 0; m_rd = '0;
    end else begin
`ifdef FIR_COEFF_READBACK_EN
      m_rd = (int'(rd_addr) < TC) ? m_active[rd_addr] : '0;
`endif
      m_upd = 0;
      if (m_commit) begin
        for (int k = 0; k < TC; k++) m_active[k] = m_frame[k];
        m_commit = 0;
        m_upd    = 1;
      end else if (m_loading) begin
        if (start) begin
          m_frame.delete();
          m_err = 0;
        end else if (cfg_valid) begin
          m_frame.push_back(cfg_data);
          if (cfg_last || m_frame.size() == TC) begin
            m_loading = 0;
            if (cfg_last && m_frame.size() == TC) m_commit = 1;
            else m_err = 1;
          end
        end
      end else if (start) begin
        m_loading = 1;
        m_frame.delete();
        m_err = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_taps(input string nm, input logic [TC*TW-1:0] exp);
    int bad;
    bad = -1;
    for (int k = TC - 1; k >= 0; k--)
      if (taps_flat[k*TW +: TW] !== exp[k*TW +: TW]) bad = k;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s tap %0d: got %h expected %h at %0t", nm, bad,
               taps_flat[bad*TW +: TW], exp[bad*TW +: TW], $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [TC*TW-1:0] exp_flat;
      for (int k = 0; k < TC; k++) exp_flat[k*TW +: TW] = m_active[k];
      chk_taps("model taps_flat", exp_flat);
      chk("model cfg_ready", TW'(cfg_ready), TW'(m_loading));
      chk("model busy", TW'(busy), TW'(m_loading || m_commit));
      chk("model load_err", TW'(load_err), TW'(m_err));
      chk("model coeff_update", TW'(coeff_update), TW'(m_upd));
`ifdef FIR_COEFF_READBACK_EN
      chk("model rd_data", rd_data, m_rd);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [TW-1:0] d, input logic last, input int gap);
    int t;
    repeat (gap) begin
      cfg_valid = 1'b0;
      step();
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    t = 0;
    while (!cfg_ready && t < 20) begin
      step();
      t++;
    end
    if (!cfg_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_word timeout: cfg_ready got 0 expected 1 at %0t", $time);
    end
    step();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic ramp_frame();
    pulse_start();
    for (int k = 0; k < TC; k++) send_word(TW'(k - 51), k == TC - 1, 0);
  endtask

  logic [TC*TW-1:0] all_min;

  initial begin
    for (int k = 0; k < TC; k++) all_min[k*TW +: TW] = 32'h8000_0000;

    // Reset, no frame.
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step();
    @(negedge clk);
    chk_taps("reset taps", '0);
    chk("reset cfg_ready", TW'(cfg_ready), 32'd0);
    chk("reset busy", TW'(busy), 32'd0);
    chk("reset load_err", TW'(load_err), 32'd0);

    // Words in IDLE are ignored.
    cfg_valid = 1'b1; cfg_data = 32'd77; cfg_last = 1'b1;
    repeat (3) step();
    cfg_valid = 1'b0; cfg_last = 1'b0;
    @(negedge clk);
    chk("idle word load_err", TW'(load_err), 32'd0);

    // Ramp frame; the word offered alongside start must not be taken.
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'd999; cfg_last = 1'b1;
    step();
    start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
    for (int k = 0; k < TC; k++) send_word(TW'(k - 51), k == TC - 1, 0);
    @(negedge clk);
    chk("ramp edge1 coeff_update", TW'(coeff_update), 32'd0);
    chk("ramp edge1 busy", TW'(busy), 32'd1);
    step();
    @(negedge clk);
    chk("ramp edge2 coeff_update", TW'(coeff_update), 32'd1);
    chk("ramp tap0", taps_flat[0 +: TW], 32'hFFFF_FFCD);
    chk("ramp tap101", taps_flat[101*TW +: TW], 32'h0000_0032);
    chk("ramp load_err", TW'(load_err), 32'd0);
    chk("model pin tap0", m_active[0], 32'hFFFF_FFCD);
    chk("model pin tap101", m_active[101], 32'h0000_0032);

    // Back-to-back: start in the coeff_update cycle, short frame of 10 ones.
    pulse_start();
    for (int k = 0; k < 10; k++) send_word(32'h0000_0001, k == 9, 0);
    @(negedge clk);
    chk("short load_err", TW'(load_err), 32'd1);
    chk("short tap0 kept", taps_flat[0 +: TW], 32'hFFFF_FFCD);
    chk("short cfg_ready", TW'(cfg_ready), 32'd0);

    // Unterminated frame.
    pulse_start();
    @(negedge clk);
    chk("start clears load_err", TW'(load_err), 32'd0);
    for (int k = 0; k < TC; k++) send_word(32'h7FFF_FFFF, 1'b0, 0);
    repeat (2) step();
    @(negedge clk);
    chk("unterm load_err", TW'(load_err), 32'd1);
    chk("unterm tap5 kept", taps_flat[5*TW +: TW], 32'hFFFF_FFD2);
    chk("unterm busy", TW'(busy), 32'd0);

    // Backpressure gaps, restart after 40 words, then full frame of 0x8000_0000.
    pulse_start();
    for (int k = 0; k < 40; k++) send_word($urandom, 1'b0, $urandom_range(0, 2));
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'd123;
    step();
    start = 1'b0; cfg_valid = 1'b0;
    for (int k = 0; k < TC; k++) send_word(32'h8000_0000, k == TC - 1, $urandom_range(0, 2));
    repeat (2) step();
    @(negedge clk);
    chk_taps("restart all 0x80000000", all_min);
    chk("restart load_err", TW'(load_err), 32'd0);

    // Reset mid-frame at word 50.
    pulse_start();
    for (int k = 0; k < 50; k++) send_word(TW'(k + 1000), 1'b0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_taps("midreset taps", '0);
    chk("midreset cfg_ready", TW'(cfg_ready), 32'd0);
    chk("midreset busy", TW'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

`ifdef FIR_COEFF_READBACK_EN
    ramp_frame();
    repeat (2) step();
    rd_addr = 7'd101;
    step();
    @(negedge clk);
    chk("readback 101", rd_data, 32'h0000_0032);
    rd_addr = 7'd120;
    step();
    @(negedge clk);
    chk("readback 120", rd_data, 32'd0);
    rd_addr = 7'd0;
    step();
    @(negedge clk);
    chk("readback 0", rd_data, 32'hFFFF_FFCD);
`else
    ramp_frame();
    repeat (2) step();
    @(negedge clk);
    chk("reload tap101", taps_flat[101*TW +: TW], 32'h0000_0032);
`endif

    repeat (2) step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Runtime writer for the FIR tap-coefficient bank.
- Accepts a stream of TAP_COUNT signed coefficients over a valid/ready interface and fills a shadow bank.
- Copies the shadow bank atomically into the active bank only after a complete, correctly terminated frame.
- The active bank drives the pipelined FIR's taps as a flat bus, so the filter never sees a partially loaded coefficient set.

Parameters:
- TAP_WIDTH, 32, coefficient width (signed two's complement).
- TAP_COUNT, 102, number of taps per frame.
- IDX_WIDTH, $clog2(TAP_COUNT), width of the coefficient index counter.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins (or restarts) a load frame.
- cfg_valid  in  1  coefficient word valid.
- cfg_data  in  TAP_WIDTH  signed coefficient; index 0 first.
- cfg_last  in  1  marks the final word of the frame; sampled with cfg_valid.
- cfg_ready  out  1  loader can accept a word.
- taps_flat  out  TAP_COUNT*TAP_WIDTH  active bank; tap k occupies bits [k*TAP_WIDTH +: TAP_WIDTH].
- coeff_update  out  1  one-cycle pulse in the cycle after the active bank changes.
- busy  out  1  high in LOAD and COMMIT.
- load_err  out  1  sticky frame error; cleared by start or reset.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, idx=0.
  - Shadow and active banks are all zero, so taps_flat=0.
  - cfg_ready=0, coeff_update=0, busy=0, load_err=0.
- A word is accepted when cfg_valid && cfg_ready on a rising edge. Then shadow[idx] <= cfg_data and idx <= idx+1.
- cfg_ready is a registered output: high only in LOAD.
- State IDLE:
  - start -> LOAD; idx <= 0; load_err <= 0.
  - cfg_ready is low in IDLE, so a word presented in the same cycle as start is not accepted. The first acceptance is possible in the cycle after start.
- State LOAD:
  - Accept with cfg_last=1 and idx==TAP_COUNT-1 -> COMMIT.
  - Accept with cfg_last=1 and idx<TAP_COUNT-1 (short frame) -> IDLE, load_err <= 1. The active bank is untouched.
  - Accept with cfg_last=0 and idx==TAP_COUNT-1 (long or unterminated frame) -> IDLE, load_err <= 1. The active bank is untouched.
  - start while in LOAD restarts the frame: idx <= 0 and any word offered that cycle is dropped. Stale shadow entries are overwritten by the new frame.
- State COMMIT (exactly one cycle):
  - active <= shadow for all taps; cfg_ready=0.
  - Next state IDLE; coeff_update pulses in that next cycle.
  - start during COMMIT is ignored.
- Latency: taps_flat changes on the edge that leaves COMMIT, two clock edges after the accepted last word.
- Coefficients pass through bit-exact: no rounding or sign manipulation.
- Reset mid-frame: the partial frame is discarded and the active bank returns to zero. The filter then outputs 0 until a valid frame is committed.
- cfg_valid in IDLE is ignored; no error is raised.
- Back-to-back frames: a new start is legal in the cycle coeff_update is high.

Optional Feature:
- Macro: FIR_COEFF_READBACK_EN.
- Defined: adds ports rd_addr (in, IDX_WIDTH) and rd_data (out, TAP_WIDTH).
  - rd_data is a registered read of active[rd_addr], 1-cycle latency.
  - rd_addr >= TAP_COUNT returns 0.
  - rd_data reset value is 0.
  - A read in the cycle of a COMMIT returns the old value.
- Not defined: neither port exists, and no read mux or register is synthesized.

Decomposition:
- Package fir_pkg holds:
  - TAP_WIDTH_DEF and TAP_COUNT_DEF constants.
  - typedef coeff_t (logic signed [TAP_WIDTH-1:0]).
  - typedef enum loader_state_t {IDLE, LOAD, COMMIT}.
- Sub-module fir_coeff_bank: TAP_COUNT x TAP_WIDTH register array with async zero reset, a single write port (we/addr/wdata) and a full-bank parallel load input.
  - Instantiated twice: shadow bank uses the write port, active bank uses the parallel load.

Test Plan:
- Reset then no frame -> taps_flat==0, cfg_ready==0, busy==0, load_err==0.
- start, then 102 words with value k-51 (k=0..101) and cfg_last on word 101 -> coeff_update pulses once exactly 2 edges after the last word; tap 0 = -51, tap 101 = +50; load_err=0.
- Short frame: start, 10 words of 0x0000_0001, last on word 9 -> load_err=1, taps_flat unchanged from the previous test, returns to IDLE.
- Unterminated frame: 102 words of 0x7FFF_FFFF with cfg_last=0 -> load_err=1, no coeff_update, active bank unchanged.
- Backpressure and restart:
  - Random cfg_valid gaps, then start reasserted after 40 words, then a full 102-word frame of 0x8000_0000 -> all taps equal 0x8000_0000.
  - reset_n pulsed low at word 50 of the next frame -> taps_flat==0 immediately.
- With FIR_COEFF_READBACK_EN: after commit, rd_addr=101 -> rd_data = +50 on the next cycle; rd_addr=120 -> rd_data = 0.
